// File: rtl/axi_addr_remap_pkg.sv
// Shared types for the AXI address remapper: request/response structs,
// translation rule layout, channel FSM states and the miss counter width.
package axi_addr_remap_pkg;

  localparam int unsigned AddrWidth    = 32;
  localparam int unsigned IdWidth      = 4;
  localparam int unsigned DataWidth    = 32;
  localparam int unsigned MissCntWidth = 16;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } chan_state_e;

  typedef struct packed {
    logic [AddrWidth-1:0] base;
    logic [AddrWidth-1:0] mask;
    logic [AddrWidth-1:0] target;
  } remap_rule_t;

  typedef struct packed {
    logic [IdWidth-1:0]   id;
    logic [AddrWidth-1:0] addr;
    logic [7:0]           len;
    logic [2:0]           size;
    logic [1:0]           burst;
  } ax_chan_t;

  typedef struct packed {
    logic [DataWidth-1:0]   data;
    logic [DataWidth/8-1:0] strb;
    logic                   last;
  } w_chan_t;

  typedef struct packed {
    logic [IdWidth-1:0] id;
    logic [1:0]         resp;
  } b_chan_t;

  typedef struct packed {
    logic [IdWidth-1:0]   id;
    logic [DataWidth-1:0] data;
    logic [1:0]           resp;
    logic                 last;
  } r_chan_t;

  typedef struct packed {
    ax_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ax_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } remap_req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    ar_ready;
    logic    w_ready;
    b_chan_t b;
    logic    b_valid;
    r_chan_t r;
    logic    r_valid;
  } remap_resp_t;

endpackage

// File: rtl/axi_addr_remap_chan.sv
// One address channel (AW or AR) of the remapper: first-match rule lookup,
// registered translated address, IDLE/HOLD handshake FSM and a saturating
// miss counter. The address register only loads on IDLE->HOLD, so it stays
// frozen for the whole downstream handshake regardless of rule changes.
module axi_addr_remap_chan
  import axi_addr_remap_pkg::*;
#(
  parameter int unsigned NumRules     = 4,
  parameter int unsigned SlvAddrWidth = 32,
  parameter int unsigned MstAddrWidth = 32,
  parameter type         rule_t       = remap_rule_t
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    clear_i,
  input  logic                    slv_valid_i,
  input  logic [SlvAddrWidth-1:0] slv_addr_i,
  input  rule_t [NumRules-1:0]    rules_i,
  input  logic [MstAddrWidth-1:0] default_target_i,
  input  logic                    mst_ready_i,
  output logic                    mst_valid_o,
  output logic                    slv_ready_o,
  output logic [MstAddrWidth-1:0] mst_addr_o,
  output logic [MissCntWidth-1:0] miss_cnt_o
);

  chan_state_e             r_state;
  chan_state_e             w_state_nxt;
  logic [MstAddrWidth-1:0] r_addr;
  logic [MstAddrWidth-1:0] w_addr_nxt;
  logic [MissCntWidth-1:0] r_miss_cnt;
  logic [MissCntWidth-1:0] w_miss_cnt_nxt;
  logic                    w_take;
  logic                    w_hit;
  logic [SlvAddrWidth-1:0] w_mask;
  logic [MstAddrWidth-1:0] w_target;
  logic [MstAddrWidth-1:0] w_xlat;

  // Counter saturates at all-ones instead of wrapping back to zero.
  function automatic logic [MissCntWidth-1:0] sat_inc(input logic [MissCntWidth-1:0] v);
    return (&v) ? v : v + MissCntWidth'(1);
  endfunction

  // First-match lookup; scanning from the top down lets index 0 win ties.
  always_comb begin
    w_hit    = 1'b0;
    w_mask   = '0;
    w_target = '0;
    for (int i = int'(NumRules) - 1; i >= 0; i--) begin
      if (((slv_addr_i ^ rules_i[i].base) & rules_i[i].mask) == '0) begin
        w_hit    = 1'b1;
        w_mask   = rules_i[i].mask;
        w_target = rules_i[i].target;
      end
    end
    w_xlat = w_hit ? w_target + MstAddrWidth'(slv_addr_i & ~w_mask)
                   : default_target_i + MstAddrWidth'(slv_addr_i);
  end

  assign w_take = (r_state == IDLE) && slv_valid_i;

  // Next address and miss count; clear overrides a same-cycle miss.
  always_comb begin
    w_addr_nxt     = w_take ? w_xlat : r_addr;
    w_miss_cnt_nxt = r_miss_cnt;
    if (clear_i) begin
      w_miss_cnt_nxt = '0;
    end else if (w_take && !w_hit) begin
      w_miss_cnt_nxt = sat_inc(r_miss_cnt);
    end
  end

  // State, address and counter registers; reset drops any pending handshake.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= IDLE;
      r_addr     <= '0;
      r_miss_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_addr     <= w_addr_nxt;
      r_miss_cnt <= w_miss_cnt_nxt;
    end
  end

  // Next-state logic: capture in IDLE, leave HOLD on downstream handshake.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (slv_valid_i) w_state_nxt = HOLD;
      HOLD:    if (mst_ready_i) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Outputs: valid only while holding; upstream ready mirrors downstream ready.
  always_comb begin
    mst_valid_o = 1'b0;
    slv_ready_o = 1'b0;
    if (r_state == HOLD) begin
      mst_valid_o = 1'b1;
      slv_ready_o = mst_ready_i;
    end
  end

  assign mst_addr_o = r_addr;
  assign miss_cnt_o = r_miss_cnt;

endmodule

// File: rtl/axi_addr_remap.sv
// AXI address remapper top: two independent channel translators (AW, AR)
// plus the valid/ready gating. W, B and R, and all non-handshake AW/AR
// fields, pass straight through.
module axi_addr_remap
  import axi_addr_remap_pkg::*;
#(
  parameter int unsigned NumRules     = 4,
  parameter int unsigned SlvAddrWidth = 32,
  parameter int unsigned MstAddrWidth = 32,
  parameter type         slv_req_t    = remap_req_t,
  parameter type         axi_resp_t   = remap_resp_t,
  parameter type         rule_t       = remap_rule_t
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  slv_req_t                slv_req_i,
  output axi_resp_t               slv_resp_o,
  output slv_req_t                mst_req_o,
  input  axi_resp_t               mst_resp_i,
  output logic [MstAddrWidth-1:0] mst_aw_addr_o,
  output logic [MstAddrWidth-1:0] mst_ar_addr_o,
  input  rule_t [NumRules-1:0]    rules_i,
  input  logic [MstAddrWidth-1:0] default_target_i,
  input  logic                    clear_i,
  output logic [MissCntWidth-1:0] aw_miss_cnt_o,
  output logic [MissCntWidth-1:0] ar_miss_cnt_o
);

  logic w_aw_mst_valid;
  logic w_aw_slv_ready;
  logic w_ar_mst_valid;
  logic w_ar_slv_ready;

  axi_addr_remap_chan #(
    .NumRules     (NumRules),
    .SlvAddrWidth (SlvAddrWidth),
    .MstAddrWidth (MstAddrWidth),
    .rule_t       (rule_t)
  ) u_aw_chan (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .clear_i          (clear_i),
    .slv_valid_i      (slv_req_i.aw_valid),
    .slv_addr_i       (slv_req_i.aw.addr),
    .rules_i          (rules_i),
    .default_target_i (default_target_i),
    .mst_ready_i      (mst_resp_i.aw_ready),
    .mst_valid_o      (w_aw_mst_valid),
    .slv_ready_o      (w_aw_slv_ready),
    .mst_addr_o       (mst_aw_addr_o),
    .miss_cnt_o       (aw_miss_cnt_o)
  );

  axi_addr_remap_chan #(
    .NumRules     (NumRules),
    .SlvAddrWidth (SlvAddrWidth),
    .MstAddrWidth (MstAddrWidth),
    .rule_t       (rule_t)
  ) u_ar_chan (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .clear_i          (clear_i),
    .slv_valid_i      (slv_req_i.ar_valid),
    .slv_addr_i       (slv_req_i.ar.addr),
    .rules_i          (rules_i),
    .default_target_i (default_target_i),
    .mst_ready_i      (mst_resp_i.ar_ready),
    .mst_valid_o      (w_ar_mst_valid),
    .slv_ready_o      (w_ar_slv_ready),
    .mst_addr_o       (mst_ar_addr_o),
    .miss_cnt_o       (ar_miss_cnt_o)
  );

  // Pass everything through, overriding only the gated AW/AR handshakes.
  always_comb begin
    mst_req_o           = slv_req_i;
    mst_req_o.aw_valid  = w_aw_mst_valid;
    mst_req_o.ar_valid  = w_ar_mst_valid;
    slv_resp_o          = mst_resp_i;
    slv_resp_o.aw_ready = w_aw_slv_ready;
    slv_resp_o.ar_ready = w_ar_slv_ready;
  end

endmodule

// File: tb/tb_axi_addr_remap.sv
// Directed bench for axi_addr_remap with hand-computed expected values.
module tb_axi_addr_remap;
  import axi_addr_remap_pkg::*;

  logic              clk;
  logic              rst;
  logic              clear;
  remap_req_t        slv_req;
  remap_req_t        mst_req;
  remap_resp_t       slv_resp;
  remap_resp_t       mst_resp;
  remap_rule_t [3:0] rules;
  logic [31:0]       dflt;
  logic [31:0]       aw_addr;
  logic [31:0]       ar_addr;
  logic [15:0]       aw_miss;
  logic [15:0]       ar_miss;

  int          n_chk;
  int          n_fail;
  logic [31:0] got;
  int          lat;

  axi_addr_remap #(
    .NumRules     (4),
    .SlvAddrWidth (32),
    .MstAddrWidth (32)
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .slv_req_i        (slv_req),
    .slv_resp_o       (slv_resp),
    .mst_req_o        (mst_req),
    .mst_resp_i       (mst_resp),
    .mst_aw_addr_o    (aw_addr),
    .mst_ar_addr_o    (ar_addr),
    .rules_i          (rules),
    .default_target_i (dflt),
    .clear_i          (clear),
    .aw_miss_cnt_o    (aw_miss),
    .ar_miss_cnt_o    (ar_miss)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic remap_rule_t mk_rule(input logic [31:0] b, input logic [31:0] m,
                                          input logic [31:0] t);
    remap_rule_t r;
    r.base   = b;
    r.mask   = m;
    r.target = t;
    return r;
  endfunction

  // Present one AW/AR, wait (bounded) for the upstream handshake, then drop valid.
  task automatic ax_txn(input bit is_ar, input logic [31:0] addr,
                        output logic [31:0] xl, output int cyc);
    logic rdy;
    @(negedge clk);
    if (is_ar) begin
      slv_req.ar.addr  = addr;
      slv_req.ar_valid = 1'b1;
    end else begin
      slv_req.aw.addr  = addr;
      slv_req.aw_valid = 1'b1;
    end
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      rdy = is_ar ? slv_resp.ar_ready : slv_resp.aw_ready;
    end while (!rdy && cyc < 20);
    chk(is_ar ? "ar_handshake" : "aw_handshake", 64'(rdy), 64'd1);
    xl = is_ar ? ar_addr : aw_addr;
    @(posedge clk);
    #1;
    if (is_ar) slv_req.ar_valid = 1'b0;
    else       slv_req.aw_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    n_chk    = 0;
    n_fail   = 0;
    rst      = 1'b0;
    clear    = 1'b0;
    slv_req  = '0;
    mst_resp = '0;
    dflt     = 32'h0;
    for (int i = 0; i < 4; i++) rules[i] = mk_rule(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0);

    // Reset state, checked without any clock edge.
    #1 rst = 1'b1;
    #1;
    chk("rst_aw_valid", 64'(mst_req.aw_valid), 64'd0);
    chk("rst_ar_valid", 64'(mst_req.ar_valid), 64'd0);
    chk("rst_aw_ready", 64'(slv_resp.aw_ready), 64'd0);
    chk("rst_aw_addr", 64'(aw_addr), 64'd0);
    chk("rst_ar_addr", 64'(ar_addr), 64'd0);
    chk("rst_aw_miss", 64'(aw_miss), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Single AW hit.
    rules[0]          = mk_rule(32'h1000_0000, 32'hF000_0000, 32'h8000_0000);
    mst_resp.aw_ready = 1'b1;
    @(negedge clk);
    slv_req.aw.id    = 4'h5;
    slv_req.aw.addr  = 32'h1234_5678;
    slv_req.aw_valid = 1'b1;
    #1;
    chk("t1_idle_mst_valid", 64'(mst_req.aw_valid), 64'd0);
    chk("t1_idle_slv_ready", 64'(slv_resp.aw_ready), 64'd0);
    @(negedge clk);
    chk("t1_mst_valid", 64'(mst_req.aw_valid), 64'd1);
    chk("t1_addr", 64'(aw_addr), 64'h8234_5678);
    chk("t1_slv_ready", 64'(slv_resp.aw_ready), 64'd1);
    chk("t1_id_pass", 64'(mst_req.aw.id), 64'h5);
    @(posedge clk);
    #1 slv_req.aw_valid = 1'b0;
    chk("t1_after_hs", 64'(mst_req.aw_valid), 64'd0);
    chk("t1_no_miss", 64'(aw_miss), 64'd0);

    // Priority between overlapping rules, then an AR miss.
    rules[0]          = mk_rule(32'h2000_0000, 32'hF000_0000, 32'hA000_0000);
    rules[1]          = mk_rule(32'h2000_0000, 32'hFF00_0000, 32'hB000_0000);
    dflt              = 32'h0000_0100;
    mst_resp.ar_ready = 1'b1;
    ax_txn(1'b1, 32'h2000_0000, got, lat);
    chk("t2_prio_addr", 64'(got), 64'hA000_0000);
    chk("t2_latency", 64'(lat), 64'd1);
    chk("t2_no_miss", 64'(ar_miss), 64'd0);
    ax_txn(1'b1, 32'h7000_0010, got, lat);
    chk("t2_miss_addr", 64'(got), 64'h7000_0110);
    chk("t2_miss_cnt", 64'(ar_miss), 64'd1);

    // Backpressure: address and valid frozen while rules change.
    mst_resp.aw_ready = 1'b0;
    @(negedge clk);
    slv_req.aw.addr  = 32'h2000_0040;
    slv_req.aw_valid = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      chk("t3_hold_valid", 64'(mst_req.aw_valid), 64'd1);
      chk("t3_hold_addr", 64'(aw_addr), 64'hA000_0040);
      chk("t3_hold_ready", 64'(slv_resp.aw_ready), 64'd0);
      if (k == 0) begin
        rules[0] = mk_rule(32'h0, 32'h0, 32'hC000_0000);
        dflt     = 32'h0000_0999;
      end
      @(negedge clk);
    end
    mst_resp.aw_ready = 1'b1;
    #1;
    chk("t3_ready_follows", 64'(slv_resp.aw_ready), 64'd1);
    @(posedge clk);
    #1 slv_req.aw_valid = 1'b0;
    chk("t3_single_hs", 64'(mst_req.aw_valid), 64'd0);
    chk("t3_addr_kept", 64'(aw_addr), 64'hA000_0040);
    @(negedge clk);
    chk("t3_no_second_hs", 64'(mst_req.aw_valid), 64'd0);

    // Concurrent AW/AR with W presented first; B and R echoed.
    rules[0]          = mk_rule(32'h1000_0000, 32'hF000_0000, 32'h8000_0000);
    rules[1]          = mk_rule(32'h2000_0000, 32'hFF00_0000, 32'hB000_0000);
    dflt              = 32'h0000_0100;
    mst_resp.ar_ready = 1'b1;
    @(negedge clk);
    slv_req.w.data    = 32'hDEAD_BEEF;
    slv_req.w.strb    = 4'hF;
    slv_req.w.last    = 1'b1;
    slv_req.w_valid   = 1'b1;
    slv_req.b_ready   = 1'b1;
    slv_req.r_ready   = 1'b1;
    mst_resp.w_ready  = 1'b1;
    mst_resp.b.id     = 4'h3;
    mst_resp.b.resp   = 2'h2;
    mst_resp.b_valid  = 1'b1;
    mst_resp.r.id     = 4'h6;
    mst_resp.r.data   = 32'h55AA_1234;
    mst_resp.r.resp   = 2'h0;
    mst_resp.r.last   = 1'b1;
    mst_resp.r_valid  = 1'b1;
    #1;
    chk("t4_w_data", 64'(mst_req.w.data), 64'hDEAD_BEEF);
    chk("t4_w_valid", 64'(mst_req.w_valid), 64'd1);
    chk("t4_w_ready", 64'(slv_resp.w_ready), 64'd1);
    chk("t4_b_echo", 64'(slv_resp.b), 64'h0E);
    chk("t4_b_valid", 64'(slv_resp.b_valid), 64'd1);
    chk("t4_r_data", 64'(slv_resp.r.data), 64'h55AA_1234);
    chk("t4_b_ready", 64'(mst_req.b_ready), 64'd1);
    chk("t4_aw_not_yet", 64'(mst_req.aw_valid), 64'd0);
    slv_req.aw.addr  = 32'h1000_0004;
    slv_req.aw_valid = 1'b1;
    slv_req.ar.addr  = 32'h2000_0008;
    slv_req.ar_valid = 1'b1;
    @(negedge clk);
    chk("t4_aw_addr", 64'(aw_addr), 64'h8000_0004);
    chk("t4_ar_addr", 64'(ar_addr), 64'hB000_0008);
    chk("t4_aw_valid", 64'(mst_req.aw_valid), 64'd1);
    chk("t4_ar_valid", 64'(mst_req.ar_valid), 64'd1);
    chk("t4_aw_ready", 64'(slv_resp.aw_ready), 64'd1);
    chk("t4_ar_ready", 64'(slv_resp.ar_ready), 64'd1);
    @(posedge clk);
    #1;
    slv_req.aw_valid = 1'b0;
    slv_req.ar_valid = 1'b0;
    slv_req.w_valid  = 1'b0;
    mst_resp.b_valid = 1'b0;
    mst_resp.r_valid = 1'b0;
    chk("t4_ar_miss_unchanged", 64'(ar_miss), 64'd1);

    // Saturation of the AW miss counter, then clear racing a miss.
    @(negedge clk);
    force dut.u_aw_chan.r_miss_cnt = 16'hFFFE;
    #1 release dut.u_aw_chan.r_miss_cnt;
    #1;
    chk("t5_preset", 64'(aw_miss), 64'hFFFE);
    ax_txn(1'b0, 32'h7000_0000, got, lat);
    chk("t5_miss_addr", 64'(got), 64'h7000_0100);
    chk("t5_reach_max", 64'(aw_miss), 64'hFFFF);
    ax_txn(1'b0, 32'h7000_0000, got, lat);
    ax_txn(1'b0, 32'h7000_0000, got, lat);
    chk("t5_saturated", 64'(aw_miss), 64'hFFFF);
    @(negedge clk);
    slv_req.aw.addr  = 32'h7000_0000;
    slv_req.aw_valid = 1'b1;
    clear            = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("t5_clear_wins", 64'(aw_miss), 64'd0);
    chk("t5_clear_ar", 64'(ar_miss), 64'd0);
    @(posedge clk);
    #1 slv_req.aw_valid = 1'b0;
    chk("t5_after_clear", 64'(aw_miss), 64'd0);

    // Reset while AW is holding.
    ax_txn(1'b1, 32'h7000_0000, got, lat);
    chk("t6_ar_miss_pre", 64'(ar_miss), 64'd1);
    mst_resp.aw_ready = 1'b0;
    @(negedge clk);
    slv_req.aw.addr  = 32'h1000_0010;
    slv_req.aw_valid = 1'b1;
    @(negedge clk);
    chk("t6_hold_valid", 64'(mst_req.aw_valid), 64'd1);
    chk("t6_hold_addr", 64'(aw_addr), 64'h8000_0010);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_valid", 64'(mst_req.aw_valid), 64'd0);
    chk("t6_rst_addr", 64'(aw_addr), 64'd0);
    chk("t6_rst_ready", 64'(slv_resp.aw_ready), 64'd0);
    chk("t6_rst_ar_miss", 64'(ar_miss), 64'd0);
    @(negedge clk);
    rst               = 1'b0;
    mst_resp.aw_ready = 1'b1;
    @(negedge clk);
    chk("t6_re_valid", 64'(mst_req.aw_valid), 64'd1);
    chk("t6_re_addr", 64'(aw_addr), 64'h8000_0010);
    chk("t6_re_ready", 64'(slv_resp.aw_ready), 64'd1);
    @(posedge clk);
    #1 slv_req.aw_valid = 1'b0;
    chk("t6_re_done", 64'(mst_req.aw_valid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
